// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate self-test sequencer: FSM state encoding and vector sizing.
package gate_seq_pkg;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned VEC_W   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StSample,
        StDone
    } state_e;

endpackage

// File: rtl/settle_counter.sv
// Settle-time counter: cleared by load, counts while enabled, flags the last settle cycle.
module settle_counter #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic term
);

    // With SETTLE==0 the settle state is never entered, so the terminal value is irrelevant.
    localparam logic [CNT_W-1:0] TERM_VAL = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign term = (count_q == TERM_VAL);

endmodule

// File: rtl/gate_seq_ctrl.sv
// Self-test sequencer for a 2-input gate: steps 00..11 onto the gate, waits, samples,
// and compares each response against an expected truth table.
module gate_seq_ctrl
    import gate_seq_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] EXPECT = 4'b1110,
    parameter int unsigned        SETTLE = 2,
    parameter int unsigned        CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               gate_out,
    output logic               x,
    output logic               y,
    output logic [VEC_W-1:0]   vec_idx,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] fail_mask
);

    localparam logic HAS_SETTLE = (SETTLE != 0);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [1:0]         xy_q, xy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [NUM_VEC-1:0] fail_q, fail_d;
    logic               cnt_load, cnt_en, cnt_term;

    settle_counter #(
        .CNT_W  (CNT_W),
        .SETTLE (SETTLE)
    ) u_settle_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .en    (cnt_en),
        .term  (cnt_term)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        xy_d     = xy_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        fail_d   = fail_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StApply;
                    vec_d   = '0;
                    xy_d    = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StApply: begin
                if (HAS_SETTLE) begin
                    state_d  = StSettle;
                    cnt_load = 1'b1;
                end else begin
                    state_d = StSample;
                end
            end
            StSettle: begin
                cnt_en = 1'b1;
                if (cnt_term) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                fail_d[vec_q] = (gate_out != EXPECT[vec_q]);
                if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    // Includes the last vector's result, so pass is valid alongside done.
                    pass_d  = (fail_d == '0);
                end else begin
                    state_d = StApply;
                    vec_d   = vec_q + 1'b1;
                    xy_d    = vec_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            xy_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            xy_q    <= xy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign x         = xy_q[1];
    assign y         = xy_q[0];
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: three instances (SETTLE=2, 0, 1) each driving its own gate model.
module tb_gate_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a [3];
    logic       gate_a  [3];
    logic       x_a     [3];
    logic       y_a     [3];
    logic [1:0] vec_a   [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic       pass_a  [3];
    logic [3:0] fm_a    [3];
    int         mode_a  [3];
    logic [2:0] dly_a   [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         inst;
        int         lat;
        logic [3:0] mask;
        logic       pass;
    } exp_t;

    exp_t sb[$];

    // Index 0: SETTLE=2, index 1: SETTLE=0, index 2: SETTLE=1.
    gate_seq_ctrl #(.EXPECT(4'b1110), .SETTLE(2), .CNT_W(8)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .gate_out(gate_a[0]),
        .x(x_a[0]), .y(y_a[0]), .vec_idx(vec_a[0]), .busy(busy_a[0]),
        .done(done_a[0]), .pass(pass_a[0]), .fail_mask(fm_a[0])
    );

    gate_seq_ctrl #(.EXPECT(4'b1110), .SETTLE(0), .CNT_W(8)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .gate_out(gate_a[1]),
        .x(x_a[1]), .y(y_a[1]), .vec_idx(vec_a[1]), .busy(busy_a[1]),
        .done(done_a[1]), .pass(pass_a[1]), .fail_mask(fm_a[1])
    );

    gate_seq_ctrl #(.EXPECT(4'b1110), .SETTLE(1), .CNT_W(8)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .gate_out(gate_a[2]),
        .x(x_a[2]), .y(y_a[2]), .vec_idx(vec_a[2]), .busy(busy_a[2]),
        .done(done_a[2]), .pass(pass_a[2]), .fail_mask(fm_a[2])
    );

    // Slow OR cell: output reflects a new input only 3 edges after it is applied.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            dly_a[i] <= {dly_a[i][1:0], x_a[i] | y_a[i]};
        end
    end

    // Modes: 0 OR, 1 stuck-at-0, 2 AND, 3 slow OR.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            gate_a[i] = 1'b0;
            case (mode_a[i])
                0:       gate_a[i] = x_a[i] | y_a[i];
                1:       gate_a[i] = 1'b0;
                2:       gate_a[i] = x_a[i] & y_a[i];
                default: gate_a[i] = dly_a[i][2];
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag, input int i);
        check(tag, 32'({busy_a[i], done_a[i], pass_a[i], fm_a[i], vec_a[i], x_a[i], y_a[i]}), 0);
    endtask

    // One full run on instance i; optionally pulses start again while vec_idx==2.
    task automatic run(input int i, input bit mid, input int lat, input logic [3:0] mask,
                       input logic p);
        exp_t       e;
        int         n;
        int         extra;
        bit         pulsed;
        bit         xy_bad;
        logic [7:0] seq;
        logic [1:0] last;

        sb.push_back('{i, lat, mask, p});
        @(negedge clk);
        start_a[i] = 1'b1;
        @(posedge clk);
        #1;
        start_a[i] = 1'b0;
        check("busy_on_accept", 32'(busy_a[i]), 1);
        check("clear_on_accept", 32'({pass_a[i], fm_a[i]}), 0);

        seq    = {6'd0, vec_a[i]};
        last   = vec_a[i];
        xy_bad = 1'b0;
        pulsed = 1'b0;
        n      = 0;
        while (n < 200 && done_a[i] !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
            if (mid && !pulsed && vec_a[i] == 2'd2) begin
                start_a[i] = 1'b1;
                pulsed     = 1'b1;
            end else begin
                start_a[i] = 1'b0;
            end
            if ({x_a[i], y_a[i]} !== vec_a[i]) xy_bad = 1'b1;
            if (vec_a[i] !== last) begin
                seq  = {seq[5:0], vec_a[i]};
                last = vec_a[i];
            end
        end
        start_a[i] = 1'b0;
        check("done_seen", 32'(done_a[i]), 1);

        e = sb.pop_front();
        check("done_inst", 32'(i), 32'(e.inst));
        check("done_latency", 32'(n), 32'(e.lat));
        check("fail_mask", 32'(fm_a[i]), 32'(e.mask));
        check("pass", 32'(pass_a[i]), 32'(e.pass));
        check("vec_order", 32'(seq), 32'h1b);
        check("xy_follows_vec", 32'(xy_bad), 0);

        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done_a[i]), 0);
        check("busy_after_done", 32'(busy_a[i]), 0);

        repeat (3) @(posedge clk);
        #1;
        check("hold_mask", 32'(fm_a[i]), 32'(e.mask));
        check("hold_pass", 32'(pass_a[i]), 32'(e.pass));
        check("vec_no_wrap", 32'(vec_a[i]), 3);

        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_a[i] === 1'b1) extra++;
        end
        check("no_extra_done", 32'(extra), 0);
    endtask

    initial begin
        int n;
        int extra;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            mode_a[i]  = 0;
        end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_cleared("reset_state", i);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // OR cell, SETTLE=2
        run(0, 1'b0, 16, 4'b0000, 1'b1);
        // Stuck-at-0 and AND cells
        mode_a[0] = 1;
        run(0, 1'b0, 16, 4'b1110, 1'b0);
        mode_a[0] = 2;
        run(0, 1'b0, 16, 4'b0110, 1'b0);
        // SETTLE=0: two cycles per vector
        run(1, 1'b0, 8, 4'b0000, 1'b1);
        // start pulsed mid-run is ignored
        mode_a[0] = 0;
        run(0, 1'b1, 16, 4'b0000, 1'b1);

        // start held high: back-to-back runs with a single IDLE cycle between
        @(negedge clk);
        start_a[0] = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (n < 100 && done_a[0] !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("held_first_latency", 32'(n), 16);
        @(posedge clk);
        #1;
        check("held_idle_busy", 32'(busy_a[0]), 0);
        @(posedge clk);
        #1;
        check("held_reaccept_busy", 32'(busy_a[0]), 1);
        start_a[0] = 1'b0;
        n = 0;
        while (n < 100 && done_a[0] !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("held_second_latency", 32'(n), 16);
        check("held_second_pass", 32'(pass_a[0]), 1);
        repeat (3) @(posedge clk);

        // Asynchronous reset during the settle phase of vector 1
        @(negedge clk);
        start_a[0] = 1'b1;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        n = 0;
        while (n < 100 && vec_a[0] !== 2'd1) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check("busy_before_abort", 32'(busy_a[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async_reset_clear", 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_a[0] === 1'b1) extra++;
        end
        check("no_done_after_abort", 32'(extra), 0);
        run(0, 1'b0, 16, 4'b0000, 1'b1);

        // Slow gate: SETTLE=1 samples stale outputs, SETTLE=2 waits long enough
        mode_a[2] = 3;
        run(2, 1'b0, 12, 4'b0010, 1'b0);
        mode_a[0] = 3;
        run(0, 1'b0, 16, 4'b0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
